ff_m_mem_rd_cell: RTL and testbench

Read-side companion to the multi-write-port flop memory cell. It takes the cell's full DEPTH-bit state vector and serves NUMRDPT independent single-bit read ports through a fixed-latency registered pipeline. A dump engine streams a coherent snapshot of the whole array out one bit per cycle; it is the read-out counterpart to the cell's backdoor bulk load, used by debug and checkers. It sits beside the flop array and holds no array storage of its own.

---
 rtl/ff_m_mem_rd_cell_if.sv | 30 +++
 rtl/ff_m_mem_rd_cell.sv | 105 ++++++++++
 tb/tb_ff_m_mem_rd_cell.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ff_m_mem_rd_cell_if.sv
// Read/dump bus between the flop-array read cell and its user.
// The cell uses the slave modport; the requester (or bench) uses master.
interface ff_m_mem_rd_cell_if #(
    parameter int NUMRDPT = 2,
    parameter int BITADDR = 4
);
    localparam int DEPTH = 1 << BITADDR;

    logic [DEPTH-1:0]           mem_bits;
    logic [NUMRDPT-1:0]         read;
    logic [NUMRDPT*BITADDR-1:0] rdaddr;
    logic [NUMRDPT-1:0]         rd_vld;
    logic [NUMRDPT-1:0]         rd_dout;
    logic                       dump_req;
    logic                       dump_busy;
    logic                       dump_vld;
    logic [BITADDR-1:0]         dump_addr;
    logic                       dump_bit;
    logic                       dump_done;

    modport master (
        output mem_bits, read, rdaddr, dump_req,
        input  rd_vld, rd_dout, dump_busy, dump_vld, dump_addr, dump_bit, dump_done
    );

    modport slave (
        input  mem_bits, read, rdaddr, dump_req,
        output rd_vld, rd_dout, dump_busy, dump_vld, dump_addr, dump_bit, dump_done
    );
endinterface

// File: rtl/ff_m_mem_rd_cell.sv
// Read side of the multi-write flop memory cell: NUMRDPT fixed-latency bit
// read ports plus a snapshot dump engine that streams the array one bit per cycle.
module ff_m_mem_rd_cell #(
    parameter int NUMRDPT  = 2,
    parameter int BITADDR  = 4,
    parameter int RD_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    ff_m_mem_rd_cell_if.slave bus
);
    localparam int DEPTH = 1 << BITADDR;
    localparam logic [BITADDR-1:0] LAST_ADDR = {BITADDR{1'b1}};

    // Stage p0: port address decode against the live array state
    logic [NUMRDPT-1:0] w_rd_bit_p0;

    always_comb begin
        w_rd_bit_p0 = '0;
        for (int i = 0; i < NUMRDPT; i++) begin
            w_rd_bit_p0[i] = bus.mem_bits[bus.rdaddr[(i+1)*BITADDR-1 -: BITADDR]];
        end
    end

    // Stages p0..p(RD_DELAY-1): {valid, data} shift pipeline per port
    logic [NUMRDPT-1:0] r_vld_p [RD_DELAY];
    logic [NUMRDPT-1:0] r_dat_p [RD_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_DELAY; s++) begin
                r_vld_p[s] <= '0;
                r_dat_p[s] <= '0;
            end
        end else begin
            r_vld_p[0] <= bus.read;
            r_dat_p[0] <= bus.read & w_rd_bit_p0;
            for (int s = 1; s < RD_DELAY; s++) begin
                r_vld_p[s] <= r_vld_p[s-1];
                r_dat_p[s] <= r_dat_p[s-1];
            end
        end
    end

    assign bus.rd_vld  = r_vld_p[RD_DELAY-1];
    assign bus.rd_dout = r_vld_p[RD_DELAY-1] & r_dat_p[RD_DELAY-1];

    // Dump engine: snapshot at start so later writes never leak into the stream
    typedef enum logic [0:0] {S_IDLE, S_RUN} dump_state_t;

    dump_state_t        r_state;
    logic [DEPTH-1:0]   r_snap;
    logic [BITADDR-1:0] r_cnt;
    logic               r_dump_vld;
    logic               r_dump_bit;
    logic               r_dump_done;
    logic               r_dump_busy;

    logic               w_last;
    logic               w_start;
    logic [BITADDR-1:0] w_cnt_nxt;

    // The edge leaving the last bit is the FSM's return to idle, so a held
    // request restarts there without a dead cycle.
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST_ADDR);
    assign w_start   = bus.dump_req && ((r_state == S_IDLE) || w_last);
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_snap      <= '0;
            r_cnt       <= '0;
            r_dump_vld  <= 1'b0;
            r_dump_bit  <= 1'b0;
            r_dump_done <= 1'b0;
            r_dump_busy <= 1'b0;
        end else if (w_start) begin
            r_state     <= S_RUN;
            r_snap      <= bus.mem_bits;
            r_cnt       <= '0;
            r_dump_vld  <= 1'b1;
            r_dump_bit  <= bus.mem_bits[0];
            r_dump_done <= 1'b0;
            r_dump_busy <= 1'b1;
        end else if ((r_state == S_RUN) && !w_last) begin
            r_cnt       <= w_cnt_nxt;
            r_dump_bit  <= r_snap[w_cnt_nxt];
            r_dump_done <= (w_cnt_nxt == LAST_ADDR);
        end else begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dump_vld  <= 1'b0;
            r_dump_bit  <= 1'b0;
            r_dump_done <= 1'b0;
            r_dump_busy <= 1'b0;
        end
    end

    assign bus.dump_busy = r_dump_busy;
    assign bus.dump_vld  = r_dump_vld;
    assign bus.dump_addr = r_cnt;
    assign bus.dump_bit  = r_dump_bit;
    assign bus.dump_done = r_dump_done;
endmodule

// File: tb/tb_ff_m_mem_rd_cell.sv
// Directed bench for ff_m_mem_rd_cell: read-port vector table plus dump,
// re-request, held-request and reset sequences.
module tb_ff_m_mem_rd_cell;
    localparam int NUMRDPT  = 2;
    localparam int BITADDR  = 4;
    localparam int RD_DELAY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ff_m_mem_rd_cell_if #(.NUMRDPT(NUMRDPT), .BITADDR(BITADDR)) bus_if ();

    ff_m_mem_rd_cell #(
        .NUMRDPT (NUMRDPT),
        .BITADDR (BITADDR),
        .RD_DELAY(RD_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rd;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [15:0] mem;
        logic [1:0]  ev;
        logic [1:0]  ed;
    } rvec_t;

    rvec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {vld, busy, done, bit, addr}
    function automatic logic [31:0] dump_vec();
        return {24'd0, bus_if.dump_vld, bus_if.dump_busy, bus_if.dump_done,
                bus_if.dump_bit, bus_if.dump_addr};
    endfunction

    task automatic chk_dump_bit(input string name, input int k, input logic [15:0] snap);
        logic [3:0] a;
        a = 4'(k);
        chk($sformatf("%s_addr%0d", name, k), dump_vec(),
            {24'd0, 1'b1, 1'b1, (k == 15), snap[a], a});
    endtask

    task automatic chk_dump_idle(input string name);
        chk(name, dump_vec(), 32'd0);
    endtask

    task automatic chk_read(input string name, input logic [1:0] ev, input logic [1:0] ed);
        chk(name, {28'd0, bus_if.rd_vld, bus_if.rd_dout}, {28'd0, ev, ed});
    endtask

    initial begin
        bus_if.mem_bits = 16'h0000;
        bus_if.read     = 2'b11;
        bus_if.rdaddr   = '0;
        bus_if.dump_req = 1'b1;

        // Reset with read and dump_req asserted: rst wins
        rst = 1'b1;
        tick();
        chk_read("rst_read_c0", 2'b00, 2'b00);
        chk_dump_idle("rst_dump_c0");
        tick();
        chk_read("rst_read_c1", 2'b00, 2'b00);
        chk_dump_idle("rst_dump_c1");
        rst = 1'b0;
        bus_if.read     = 2'b00;
        bus_if.dump_req = 1'b0;
        tick();
        chk_read("post_rst_read", 2'b00, 2'b00);
        chk_dump_idle("post_rst_dump");

        // Read vectors: row k's expected outputs come from row k-1's read
        tbl[0] = '{2'b11, 4'd0,  4'd15, 16'hA5C3, 2'b00, 2'b00};
        tbl[1] = '{2'b11, 4'd2,  4'd4,  16'hA5C3, 2'b11, 2'b11};
        tbl[2] = '{2'b11, 4'd6,  4'd9,  16'hA5C3, 2'b11, 2'b00};
        tbl[3] = '{2'b11, 4'd13, 4'd13, 16'hA5C3, 2'b11, 2'b01};
        tbl[4] = '{2'b01, 4'd8,  4'd0,  16'hA5C3, 2'b11, 2'b11};
        tbl[5] = '{2'b10, 4'd15, 4'd1,  16'hA5C3, 2'b01, 2'b01};
        tbl[6] = '{2'b11, 4'd0,  4'd0,  16'h0000, 2'b10, 2'b10};
        tbl[7] = '{2'b00, 4'd0,  4'd0,  16'hA5C3, 2'b11, 2'b00};
        tbl[8] = '{2'b00, 4'd0,  4'd0,  16'hA5C3, 2'b00, 2'b00};
        for (int r = 0; r < 9; r++) begin
            bus_if.read     = tbl[r].rd;
            bus_if.rdaddr   = {tbl[r].a1, tbl[r].a0};
            bus_if.mem_bits = tbl[r].mem;
            tick();
            chk_read($sformatf("rdvec%0d", r), tbl[r].ev, tbl[r].ed);
        end

        // Back-to-back sweep on port 0
        bus_if.mem_bits = 16'h00FF;
        for (int i = 0; i < 18; i++) begin
            bus_if.read   = (i < 16) ? 2'b01 : 2'b00;
            bus_if.rdaddr = {4'd0, 4'(i)};
            tick();
            if (i >= 1)
                chk_read($sformatf("b2b_%0d", i - 1), {1'b0, (i - 1) < 16},
                         {1'b0, (i - 1) < 8});
        end

        // Reset drops in-flight reads
        bus_if.read   = 2'b11;
        bus_if.rdaddr = {4'd0, 4'd1};
        tick();
        bus_if.read = 2'b00;
        rst = 1'b1;
        tick();
        chk_read("rst_inflight_a", 2'b00, 2'b00);
        rst = 1'b0;
        tick();
        chk_read("rst_inflight_b", 2'b00, 2'b00);

        // Coherent dump: array changes right after the request
        bus_if.mem_bits = 16'h8001;
        bus_if.dump_req = 1'b1;
        tick();
        bus_if.dump_req = 1'b0;
        bus_if.mem_bits = 16'hFFFF;
        chk_dump_bit("coh", 0, 16'h8001);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk_dump_bit("coh", k, 16'h8001);
        end
        tick();
        chk_dump_idle("coh_end");

        // Re-request pulses while running are ignored
        bus_if.mem_bits = 16'h1234;
        bus_if.dump_req = 1'b1;
        tick();
        bus_if.dump_req = 1'b0;
        chk_dump_bit("rereq", 0, 16'h1234);
        for (int k = 1; k < 16; k++) begin
            bus_if.dump_req = (k == 4 || k == 9);
            tick();
            chk_dump_bit("rereq", k, 16'h1234);
        end
        bus_if.dump_req = 1'b0;
        tick();
        chk_dump_idle("rereq_end0");
        tick();
        chk_dump_idle("rereq_end1");

        // Held request restarts right after dump_done, with a fresh snapshot
        bus_if.mem_bits = 16'h00F0;
        bus_if.dump_req = 1'b1;
        tick();
        chk_dump_bit("held", 0, 16'h00F0);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk_dump_bit("held", k, 16'h00F0);
        end
        bus_if.mem_bits = 16'h0002;
        tick();
        chk_dump_bit("held_restart", 0, 16'h0002);
        bus_if.dump_req = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick();
            chk_dump_bit("held_restart", k, 16'h0002);
        end
        tick();
        chk_dump_idle("held_end");

        // Reset mid-dump aborts; fresh request starts from addr 0
        bus_if.mem_bits = 16'h0FF0;
        bus_if.dump_req = 1'b1;
        tick();
        bus_if.dump_req = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk_dump_bit("abort_pre", 5, 16'h0FF0);
        rst = 1'b1;
        tick();
        chk_dump_idle("abort_rst");
        rst = 1'b0;
        tick();
        chk_dump_idle("abort_after");
        bus_if.mem_bits = 16'h0001;
        bus_if.dump_req = 1'b1;
        tick();
        bus_if.dump_req = 1'b0;
        chk_dump_bit("restart", 0, 16'h0001);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk_dump_bit("restart", k, 16'h0001);
        end
        tick();
        chk_dump_idle("restart_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
